id_ex_stage: RTL
================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register with load-use hazard detection and WB->ID bypass.
//  It sits between decode and the EX-stage forwarding mux, and supplies that mux
//  with RF_A/RF_B/Ext, ra/rb, dst and the control bits for the instruction in EX.
//  It inserts one bubble on a load-use hazard and squashes on branch or interrupt flush.
//  It also counts load-use stall cycles for the performance counters.
// PARAMETERS
//  DATA_W  32  datapath / PC width (PC is word-indexed; EX uses PC+1 as link)
//  REG_AW  5   register address width; register 0 is hard zero
//  CTRL_W  8   control bundle: [0]regwrite [1]memtoreg [2]memwrite [3]alusrc [4]lui [5]jal [7:6]rsvd
//  CNT_W   16  stall counter width
// PORTS
//  clk        in   1       rising-edge clock
//  rst_n      in   1       reset, asynchronous, active-low
//  id_valid   in   1       ID holds a real instruction
//  id_pc      in   DATA_W  PC of ID instruction
//  id_ra      in   REG_AW  source A register
//  id_rb      in   REG_AW  source B register
//  id_dst     in   REG_AW  destination register
//  id_rf_a    in   DATA_W  register-file read A
//  id_rf_b    in   DATA_W  register-file read B
//  id_ext     in   DATA_W  sign/zero-extended immediate
//  id_ctrl    in   CTRL_W  decoded control bundle
//  wb_regwrite in  1       WB stage writes the register file this cycle
//  wb_dst     in   REG_AW  WB destination
//  wb_data    in   DATA_W  WB write data
//  flush      in   1       branch taken / interrupt entry: kill ID instruction
//  freeze     in   1       global hold (halt/debug): no register updates
//  cnt_clr    in   1       synchronous clear of stall_cnt
//  stall_if   out  1       hold PC and IF/ID this cycle (combinational)
//  ex_valid   out  1       EX instruction is real
//  ex_pc      out  DATA_W  registered id_pc
//  ex_ra      out  REG_AW  registered id_ra
//  ex_rb      out  REG_AW  registered id_rb
//  ex_dst     out  REG_AW  registered id_dst
//  ex_rf_a    out  DATA_W  registered A operand (after WB bypass)
//  ex_rf_b    out  DATA_W  registered B operand (after WB bypass)
//  ex_ext     out  DATA_W  registered immediate
//  ex_ctrl    out  CTRL_W  registered control bundle
//  stall_cnt  out  CNT_W   load-use bubble count, saturating
// BEHAVIOUR
//  - Reset (rst_n=0, asynchronous): every ex_* output and stall_cnt go to 0; ex_valid=0.
//  - hazard = ex_valid & ex_ctrl[1] & id_valid & ex_dst!=0 & (ex_dst==id_ra | ex_dst==id_rb).
//  - stall_if = hazard & ~flush & ~freeze. It is combinational, with no added latency.
//  - Each clock edge is resolved in this priority order:
//    - freeze: all registers hold and stall_cnt holds.
//    - flush: load a bubble (ex_valid=0, ex_ctrl=0, ex_dst=0, ex_ra=0, ex_rb=0; data fields don't-care, driven 0).
//    - hazard: load a bubble and stall_cnt+1, saturating at all-ones. ID is held upstream and re-presented next cycle.
//    - otherwise: capture the ID fields, with ex_valid=id_valid. If id_valid=0, ex_ctrl is forced to 0.
//  - WB bypass on capture:
//    - ex_rf_a = (wb_regwrite & wb_dst!=0 & wb_dst==id_ra) ? wb_data : id_rf_a; ex_rf_b likewise with id_rb.
//    - This covers the register-file read-before-write case.
//  - Load-use costs exactly 1 bubble: the bubble in EX has ctrl=0, so the hazard clears the following cycle.
//  - cnt_clr has priority over the increment, but not over freeze.
//  - flush together with hazard: flush wins, stall_if=0 and no count.
//  - A reset asserted mid-stall clears state; the first cycle after release captures normally.
// TESTING
//  - Reset: rst_n=0 mid-cycle -> all outputs 0 immediately; after release, ex_valid follows id_valid next edge.
//  - Load-use: EX lw r5 (ctrl=0x03, dst=5), ID add ra=5 -> stall_if=1 one cycle, then ex_valid=0, stall_cnt=1; next cycle add captured.
//  - r0 and no-hazard cases: EX load dst=0 with ID ra=0 -> stall_if=0. EX non-load dst=5 -> no stall.
//  - WB bypass: wb_regwrite=1, wb_dst=7, wb_data=0xDEADBEEF, id_rb=7, id_rf_b=0x1234 -> ex_rf_b=0xDEADBEEF.
//  - Flush+hazard: both asserted -> stall_if=0, bubble loaded, stall_cnt unchanged. Freeze -> all ex_* hold.
//  - Saturation: CNT_W=4, 17 load-use stalls -> stall_cnt=0xF; cnt_clr -> 0.

Source files
------------

// File: rtl/id_ex_stage_if.sv
// ID/EX stage bundle: decode-side operands and control, WB bypass, pipeline
// control inputs, and the registered EX-side outputs.
interface id_ex_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
);
  // Decode side
  logic              id_valid;
  logic [DATA_W-1:0] id_pc;
  logic [REG_AW-1:0] id_ra;
  logic [REG_AW-1:0] id_rb;
  logic [REG_AW-1:0] id_dst;
  logic [DATA_W-1:0] id_rf_a;
  logic [DATA_W-1:0] id_rf_b;
  logic [DATA_W-1:0] id_ext;
  logic [CTRL_W-1:0] id_ctrl;
  // Write-back bypass
  logic              wb_regwrite;
  logic [REG_AW-1:0] wb_dst;
  logic [DATA_W-1:0] wb_data;
  // Pipeline control
  logic              flush;
  logic              freeze;
  logic              cnt_clr;
  // EX side
  logic              stall_if;
  logic              ex_valid;
  logic [DATA_W-1:0] ex_pc;
  logic [REG_AW-1:0] ex_ra;
  logic [REG_AW-1:0] ex_rb;
  logic [REG_AW-1:0] ex_dst;
  logic [DATA_W-1:0] ex_rf_a;
  logic [DATA_W-1:0] ex_rf_b;
  logic [DATA_W-1:0] ex_ext;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [CNT_W-1:0]  stall_cnt;

  // Surrounding pipeline drives decode/WB/control and observes EX
  modport master (
    output id_valid, id_pc, id_ra, id_rb, id_dst, id_rf_a, id_rf_b, id_ext, id_ctrl,
    output wb_regwrite, wb_dst, wb_data, flush, freeze, cnt_clr,
    input  stall_if, ex_valid, ex_pc, ex_ra, ex_rb, ex_dst, ex_rf_a, ex_rf_b,
    input  ex_ext, ex_ctrl, stall_cnt
  );

  // The ID/EX stage itself
  modport slave (
    input  id_valid, id_pc, id_ra, id_rb, id_dst, id_rf_a, id_rf_b, id_ext, id_ctrl,
    input  wb_regwrite, wb_dst, wb_data, flush, freeze, cnt_clr,
    output stall_if, ex_valid, ex_pc, ex_ra, ex_rb, ex_dst, ex_rf_a, ex_rf_b,
    output ex_ext, ex_ctrl, stall_cnt
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, WB->ID operand
// bypass, branch/interrupt squash, global freeze and a saturating counter of
// load-use bubbles.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  id_ex_stage_if.slave  bus
);

  localparam int CTRL_MEMTOREG = 1;

  logic              ex_valid_q, ex_valid_d;
  logic [DATA_W-1:0] ex_pc_q,    ex_pc_d;
  logic [REG_AW-1:0] ex_ra_q,    ex_ra_d;
  logic [REG_AW-1:0] ex_rb_q,    ex_rb_d;
  logic [REG_AW-1:0] ex_dst_q,   ex_dst_d;
  logic [DATA_W-1:0] ex_rf_a_q,  ex_rf_a_d;
  logic [DATA_W-1:0] ex_rf_b_q,  ex_rf_b_d;
  logic [DATA_W-1:0] ex_ext_q,   ex_ext_d;
  logic [CTRL_W-1:0] ex_ctrl_q,  ex_ctrl_d;
  logic [CNT_W-1:0]  cnt_q,      cnt_d;

  logic              hazard;
  logic              byp_a;
  logic              byp_b;
  logic [DATA_W-1:0] rf_a_fwd;
  logic [DATA_W-1:0] rf_b_fwd;

  // A load in EX whose destination feeds the ID instruction; r0 never hazards
  assign hazard = ex_valid_q & ex_ctrl_q[CTRL_MEMTOREG] & bus.id_valid &
                  (ex_dst_q != '0) &
                  ((ex_dst_q == bus.id_ra) | (ex_dst_q == bus.id_rb));

  assign bus.stall_if = hazard & ~bus.flush & ~bus.freeze;

  // The register file is read before WB writes it, so take WB data directly
  assign byp_a    = bus.wb_regwrite & (bus.wb_dst != '0) & (bus.wb_dst == bus.id_ra);
  assign byp_b    = bus.wb_regwrite & (bus.wb_dst != '0) & (bus.wb_dst == bus.id_rb);
  assign rf_a_fwd = byp_a ? bus.wb_data : bus.id_rf_a;
  assign rf_b_fwd = byp_b ? bus.wb_data : bus.id_rf_b;

  // Next-state: freeze > flush > hazard bubble > capture; clear beats increment
  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_pc_d    = ex_pc_q;
    ex_ra_d    = ex_ra_q;
    ex_rb_d    = ex_rb_q;
    ex_dst_d   = ex_dst_q;
    ex_rf_a_d  = ex_rf_a_q;
    ex_rf_b_d  = ex_rf_b_q;
    ex_ext_d   = ex_ext_q;
    ex_ctrl_d  = ex_ctrl_q;
    cnt_d      = cnt_q;
    if (!bus.freeze) begin
      if (bus.flush || hazard) begin
        // Bubble: control zeroed so the hazard clears on the next cycle
        ex_valid_d = 1'b0;
        ex_pc_d    = '0;
        ex_ra_d    = '0;
        ex_rb_d    = '0;
        ex_dst_d   = '0;
        ex_rf_a_d  = '0;
        ex_rf_b_d  = '0;
        ex_ext_d   = '0;
        ex_ctrl_d  = '0;
      end else begin
        ex_valid_d = bus.id_valid;
        ex_pc_d    = bus.id_pc;
        ex_ra_d    = bus.id_ra;
        ex_rb_d    = bus.id_rb;
        ex_dst_d   = bus.id_dst;
        ex_rf_a_d  = rf_a_fwd;
        ex_rf_b_d  = rf_b_fwd;
        ex_ext_d   = bus.id_ext;
        ex_ctrl_d  = bus.id_valid ? bus.id_ctrl : '0;
      end
      if (bus.cnt_clr) begin
        cnt_d = '0;
      end else if (hazard && !bus.flush && (cnt_q != '1)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Pipeline register and stall counter, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q <= 1'b0;
      ex_pc_q    <= '0;
      ex_ra_q    <= '0;
      ex_rb_q    <= '0;
      ex_dst_q   <= '0;
      ex_rf_a_q  <= '0;
      ex_rf_b_q  <= '0;
      ex_ext_q   <= '0;
      ex_ctrl_q  <= '0;
      cnt_q      <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_pc_q    <= ex_pc_d;
      ex_ra_q    <= ex_ra_d;
      ex_rb_q    <= ex_rb_d;
      ex_dst_q   <= ex_dst_d;
      ex_rf_a_q  <= ex_rf_a_d;
      ex_rf_b_q  <= ex_rf_b_d;
      ex_ext_q   <= ex_ext_d;
      ex_ctrl_q  <= ex_ctrl_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.ex_valid  = ex_valid_q;
  assign bus.ex_pc     = ex_pc_q;
  assign bus.ex_ra     = ex_ra_q;
  assign bus.ex_rb     = ex_rb_q;
  assign bus.ex_dst    = ex_dst_q;
  assign bus.ex_rf_a   = ex_rf_a_q;
  assign bus.ex_rf_b   = ex_rf_b_q;
  assign bus.ex_ext    = ex_ext_q;
  assign bus.ex_ctrl   = ex_ctrl_q;
  assign bus.stall_cnt = cnt_q;

endmodule
